// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus sequencer shared by the instruction fetch and load/store paths.
// Optional `MEMARB_RR_EN selects round-robin tie-breaking; default is fixed LS priority.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              busy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR, IOWAIT} state_t;

    state_t state, next;

    logic              own_ls;
    logic [2:0]        n_q;
    logic [2:0]        icnt;
    logic [2:0]        ccnt;
    logic              issued;
    logic              pend;
    logic              rdy_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;

    logic              pick_ls;
    logic              grant;
    logic              g_store;
    logic              g_wait;
    logic [ADDR_W-1:0] g_addr;
    logic [2:0]        g_n;
    logic              cap;
    logic              last_cap;
    logic [31:0]       rbuf_nx;

    function automatic logic [2:0] beats_of(input logic [1:0] size);
        case (size)
            2'd0:    beats_of = 3'd1;
            2'd1:    beats_of = 3'd2;
            default: beats_of = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        byte_of = w[8*idx +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        put_byte = w;
        put_byte[8*idx +: 8] = b;
    endfunction

`ifdef MEMARB_RR_EN
    logic rr_ls;

    assign pick_ls = ls_req && (!if_req || rr_ls);

    // Priority passes to the requester that was not just granted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            rr_ls <= 1'b1;
        else if (rdy_in && grant)
            rr_ls <= !pick_ls;
    end
`else
    assign pick_ls = ls_req;
`endif

    assign busy   = (state != IDLE);
    assign mem_wr = wr_q & rdy_in;

    always_comb begin
        grant    = (state == IDLE) && !rob_clear && !if_done && !ls_done && (if_req || ls_req);
        g_addr   = pick_ls ? ls_addr : if_addr;
        g_n      = pick_ls ? beats_of(ls_size) : 3'd4;
        g_store  = pick_ls && ls_we;
        g_wait   = g_store && (ls_addr[17:16] == IO_HI) && io_buffer_full;
        // mem_din is only trusted when the previous cycle was not frozen.
        cap      = (state == RD) && rdy_q && pend && !rob_clear;
        last_cap = cap && ((ccnt + 3'd1) == n_q);
        rbuf_nx  = put_byte(rbuf, ccnt[1:0], mem_din);
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (grant) next = g_store ? (g_wait ? IOWAIT : WR) : RD;
            RD:      if (rob_clear || last_cap) next = IDLE;
            WR:      if (icnt == n_q) next = IDLE;
            IOWAIT:  if (!io_buffer_full) next = WR;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            own_ls   <= 1'b0;
            n_q      <= 3'd0;
            icnt     <= 3'd0;
            ccnt     <= 3'd0;
            issued   <= 1'b0;
            pend     <= 1'b0;
            rdy_q    <= 1'b0;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (rdy_in) begin
                if_done <= 1'b0;
                ls_done <= 1'b0;
                case (state)
                    IDLE: begin
                        if (grant) begin
                            own_ls <= pick_ls;
                            n_q    <= g_n;
                            ccnt   <= 3'd0;
                            pend   <= 1'b0;
                            icnt   <= 3'd0;
                            if (!g_store) begin
                                mem_a  <= g_addr;
                                issued <= 1'b1;
                                icnt   <= 3'd1;
                            end else if (!g_wait) begin
                                mem_a    <= g_addr;
                                mem_dout <= ls_wdata[7:0];
                                wr_q     <= 1'b1;
                                icnt     <= 3'd1;
                            end
                        end
                    end
                    RD: begin
                        if (rob_clear) begin
                            issued <= 1'b0;
                            pend   <= 1'b0;
                        end else if (!rdy_q) begin
                            // Resuming from a freeze: restart from the first uncaptured byte.
                            mem_a  <= addr_q + ADDR_W'(ccnt);
                            icnt   <= ccnt + 3'd1;
                            issued <= 1'b1;
                            pend   <= 1'b0;
                        end else begin
                            if (cap) begin
                                ccnt <= ccnt + 3'd1;
                                if (last_cap) begin
                                    if (own_ls) begin
                                        ls_rdata <= rbuf_nx;
                                        ls_done  <= 1'b1;
                                    end else begin
                                        if_data <= rbuf_nx;
                                        if_done <= 1'b1;
                                    end
                                end
                            end
                            pend <= issued;
                            if (issued) begin
                                if (icnt < n_q) begin
                                    mem_a <= addr_q + ADDR_W'(icnt);
                                    icnt  <= icnt + 3'd1;
                                end else begin
                                    issued <= 1'b0;
                                end
                            end
                        end
                    end
                    WR: begin
                        if (icnt == n_q) begin
                            wr_q     <= 1'b0;
                            mem_dout <= 8'd0;
                            ls_done  <= 1'b1;
                        end else begin
                            mem_a    <= addr_q + ADDR_W'(icnt);
                            mem_dout <= byte_of(wdata_q, icnt[1:0]);
                            icnt     <= icnt + 3'd1;
                        end
                    end
                    IOWAIT: begin
                        if (!io_buffer_full) begin
                            mem_a    <= addr_q;
                            mem_dout <= wdata_q[7:0];
                            wr_q     <= 1'b1;
                            icnt     <= 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Request payload and read assembly carry no reset; they are rewritten at every grant.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (grant) begin
                addr_q  <= g_addr;
                wdata_q <= ls_wdata;
                rbuf    <= '0;
            end else if (cap) begin
                rbuf <= rbuf_nx;
            end
        end
    end

endmodule
